// File: rtl/pingpong_ctrl.sv
// Ping-pong game controller: rally FSM, scoring and external speed-divider control.
// Optional macro PINGPONG_SPEEDUP_EN: each successful hit raises the divider load value.
module pingpong_ctrl #(
    parameter logic [3:0] SPEED_INIT = 4'd8,
    parameter logic [3:0] WIN_SCORE  = 4'd9
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       tick_CO,
    input  logic       BtnL,
    input  logic       BtnR,
    input  logic       Serve,
    output logic       div_CR,
    output logic       div_Ld,
    output logic [3:0] div_D,
    output logic       div_CTP,
    output logic       div_CTT,
    output logic [7:0] led,
    output logic [3:0] scoreL,
    output logic [3:0] scoreR,
    output logic       game_over
);

    typedef enum logic [2:0] {
        IDLE,
        MOVE_R,
        MOVE_L,
        POINT,
        OVER
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_pos, w_pos_nxt;
    logic [3:0] r_scoreL, w_scoreL_nxt;
    logic [3:0] r_scoreR, w_scoreR_nxt;
    logic [3:0] r_div_D, w_div_D_nxt;
    logic [3:0] w_div_hit;
    logic       r_server, w_server_nxt;   // 0 = left player serves
    logic       r_btnl_prev, r_btnr_prev, r_serve_prev;
    logic       w_evt_l, w_evt_r, w_evt_serve;

    assign w_evt_l     = BtnL  & ~r_btnl_prev;
    assign w_evt_r     = BtnR  & ~r_btnr_prev;
    assign w_evt_serve = Serve & ~r_serve_prev;

`ifdef PINGPONG_SPEEDUP_EN
    assign w_div_hit = (r_div_D < 4'd14) ? r_div_D + 4'd1 : 4'd14;
`else
    assign w_div_hit = r_div_D;
`endif

    always_ff @(posedge CP) begin
        if (!CR) begin
            r_state      <= IDLE;
            r_pos        <= '0;
            r_scoreL     <= '0;
            r_scoreR     <= '0;
            r_div_D      <= SPEED_INIT;
            r_server     <= 1'b0;
            r_btnl_prev  <= 1'b0;
            r_btnr_prev  <= 1'b0;
            r_serve_prev <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pos        <= w_pos_nxt;
            r_scoreL     <= w_scoreL_nxt;
            r_scoreR     <= w_scoreR_nxt;
            r_div_D      <= w_div_D_nxt;
            r_server     <= w_server_nxt;
            r_btnl_prev  <= BtnL;
            r_btnr_prev  <= BtnR;
            r_serve_prev <= Serve;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pos_nxt    = r_pos;
        w_scoreL_nxt = r_scoreL;
        w_scoreR_nxt = r_scoreR;
        w_div_D_nxt  = r_div_D;
        w_server_nxt = r_server;
        div_CR       = 1'b0;
        div_CTP      = 1'b0;
        div_CTT      = 1'b0;
        div_Ld       = 1'b1;
        led          = '0;
        game_over    = 1'b0;

        case (r_state)
            IDLE, POINT: begin
                if (w_evt_serve) begin
                    w_div_D_nxt = SPEED_INIT;
                    if (r_server) begin
                        w_pos_nxt   = 3'd7;
                        w_state_nxt = MOVE_L;
                    end else begin
                        w_pos_nxt   = 3'd0;
                        w_state_nxt = MOVE_R;
                    end
                end
            end
            MOVE_R: begin
                div_CR  = 1'b1;
                div_CTP = 1'b1;
                div_CTT = 1'b1;
                div_Ld  = ~tick_CO;
                led     = 8'd1 << r_pos;
                // A hit edge wins over a simultaneous tick at the end position.
                if (r_pos == 3'd7) begin
                    if (w_evt_r) begin
                        w_state_nxt = MOVE_L;
                        w_div_D_nxt = w_div_hit;
                    end else if (tick_CO) begin
                        w_scoreL_nxt = r_scoreL + 4'd1;
                        w_server_nxt = 1'b1;
                        w_state_nxt  = (w_scoreL_nxt == WIN_SCORE) ? OVER : POINT;
                    end
                end else if (tick_CO) begin
                    w_pos_nxt = r_pos + 3'd1;
                end
            end
            MOVE_L: begin
                div_CR  = 1'b1;
                div_CTP = 1'b1;
                div_CTT = 1'b1;
                div_Ld  = ~tick_CO;
                led     = 8'd1 << r_pos;
                if (r_pos == 3'd0) begin
                    if (w_evt_l) begin
                        w_state_nxt = MOVE_R;
                        w_div_D_nxt = w_div_hit;
                    end else if (tick_CO) begin
                        w_scoreR_nxt = r_scoreR + 4'd1;
                        w_server_nxt = 1'b0;
                        w_state_nxt  = (w_scoreR_nxt == WIN_SCORE) ? OVER : POINT;
                    end
                end else if (tick_CO) begin
                    w_pos_nxt = r_pos - 3'd1;
                end
            end
            OVER: begin
                led       = '1;
                game_over = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign div_D  = r_div_D;
    assign scoreL = r_scoreL;
    assign scoreR = r_scoreR;

endmodule

// File: tb/tb_pingpong_ctrl.sv
// Bench for pingpong_ctrl: rally-level model compared every cycle, directed
// scenarios with literal expectations, then randomized play.
module tb_pingpong_ctrl;

    localparam logic [3:0] SPEED_INIT = 4'd8;
    localparam logic [3:0] WIN        = 4'd9;

    logic       CP = 1'b0;
    logic       CR = 1'b0;
    logic       tick_CO = 1'b0;
    logic       BtnL = 1'b0;
    logic       BtnR = 1'b0;
    logic       Serve = 1'b0;
    logic       div_CR, div_Ld, div_CTP, div_CTT, game_over;
    logic [3:0] div_D, scoreL, scoreR;
    logic [7:0] led;

    pingpong_ctrl #(.SPEED_INIT(SPEED_INIT), .WIN_SCORE(WIN)) dut (
        .CP(CP), .CR(CR), .tick_CO(tick_CO), .BtnL(BtnL), .BtnR(BtnR), .Serve(Serve),
        .div_CR(div_CR), .div_Ld(div_Ld), .div_D(div_D), .div_CTP(div_CTP), .div_CTT(div_CTT),
        .led(led), .scoreL(scoreL), .scoreR(scoreR), .game_over(game_over)
    );

    always #5 CP = ~CP;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Rally model: ball in play with a direction, a position and per-player scores.
    bit m_valid = 1'b0;
    bit m_over, m_play, m_srvR, pL, pR, pS, eL, eR, eS, hit;
    int m_dir, m_pos, m_sL, m_sR, m_speed, end_pos;

    always @(posedge CP) begin
        eL = BtnL && !pL;
        eR = BtnR && !pR;
        eS = Serve && !pS;
        pL = BtnL; pR = BtnR; pS = Serve;
        if (!CR) begin
            m_valid = 1'b1; m_over = 1'b0; m_play = 1'b0; m_srvR = 1'b0;
            m_pos = 0; m_dir = 1; m_sL = 0; m_sR = 0; m_speed = SPEED_INIT;
            pL = 1'b0; pR = 1'b0; pS = 1'b0;
        end else if (m_over) begin
            m_over = 1'b1;
        end else if (!m_play) begin
            if (eS) begin
                m_play  = 1'b1;
                m_speed = SPEED_INIT;
                m_pos   = m_srvR ? 7 : 0;
                m_dir   = m_srvR ? -1 : 1;
            end
        end else begin
            end_pos = (m_dir > 0) ? 7 : 0;
            hit     = (m_dir > 0) ? eR : eL;
            if (m_pos == end_pos) begin
                if (hit) begin
                    m_dir = -m_dir;
`ifdef PINGPONG_SPEEDUP_EN
                    if (m_speed < 14) m_speed++;
`endif
                end else if (tick_CO) begin
                    m_play = 1'b0;
                    if (m_dir > 0) begin m_sL++; m_srvR = 1'b1; end
                    else           begin m_sR++; m_srvR = 1'b0; end
                    if (m_sL == WIN || m_sR == WIN) m_over = 1'b1;
                end
            end else if (tick_CO) begin
                m_pos += m_dir;
            end
        end
    end

    logic [7:0] exp_led;
    always @(negedge CP) begin
        #1;
        if (m_valid) begin
            exp_led = m_over ? 8'hFF : (m_play ? (8'd1 << m_pos) : 8'h00);
            chk("led",       led,       exp_led);
            chk("scoreL",    scoreL,    m_sL);
            chk("scoreR",    scoreR,    m_sR);
            chk("game_over", game_over, m_over);
            chk("div_CR",    div_CR,    m_play);
            chk("div_CTP",   div_CTP,   m_play);
            chk("div_CTT",   div_CTT,   m_play);
            chk("div_Ld",    div_Ld,    m_play ? !tick_CO : 1);
            chk("div_D",     div_D,     m_speed);
        end
    end

    task automatic step(input bit cr, input bit tk, input bit bl, input bit br, input bit sv);
        @(negedge CP);
        CR = cr; tick_CO = tk; BtnL = bl; BtnR = br; Serve = sv;
        @(posedge CP);
        #1;
    endtask

    task automatic tick8(input bit bl, input bit br);
        repeat (7) step(1, 0, 0, 0, 0);
        step(1, 1, bl, br, 0);
    endtask

    task automatic serve();
        step(1, 0, 0, 0, 1);
    endtask

    initial begin
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("rst_led", led, 8'h00);
        chk("rst_over", game_over, 0);
        chk("rst_divCR", div_CR, 0);
        chk("rst_divD", div_D, 8);
        chk("rst_scores", {scoreL, scoreR}, 8'h00);

        serve();
        chk("serve_led", led, 8'h01);
        chk("serve_divCR", div_CR, 1);
        for (int k = 1; k < 8; k++) begin
            tick8(0, 0);
            chk("walkR_led", led, 1 << k);
        end
        tick8(0, 0);
        chk("miss_led", led, 8'h00);
        chk("miss_scoreL", scoreL, 1);
        chk("miss_scoreR", scoreR, 0);
        chk("miss_divCR", div_CR, 0);

        serve();
        chk("serveR_led", led, 8'h80);
        for (int k = 6; k >= 0; k--) begin
            tick8(0, 0);
            chk("walkL_led", led, 1 << k);
        end
        tick8(1, 0);
        chk("hitL_led", led, 8'h01);
        chk("hitL_divCR", div_CR, 1);
        for (int k = 1; k < 8; k++) begin
            tick8(0, k == 4);
            chk("walkR2_led", led, 1 << k);
        end
        tick8(0, 1);
        chk("hitR_led", led, 8'h80);
        chk("hitR_scores", {scoreL, scoreR}, 8'h10);
`ifdef PINGPONG_SPEEDUP_EN
        chk("hit2_divD", div_D, 10);
`else
        chk("hit2_divD", div_D, 8);
`endif
        tick8(0, 0);
        chk("after_hit_led", led, 8'h40);
        tick8(0, 0);
        tick8(0, 0);
        chk("pos4_led", led, 8'h10);
        step(0, 0, 0, 0, 0);
        chk("midrst_led", led, 8'h00);
        chk("midrst_scores", {scoreL, scoreR}, 8'h00);
        chk("midrst_divCR", div_CR, 0);

        serve();
        repeat (8) tick8(0, 0);
        for (int p = 2; p <= 9; p++) begin
            serve();
            repeat (7) tick8(0, 0);
            tick8(1, 0);
            repeat (7) tick8(0, 0);
            tick8(0, 0);
            if (p == 8) chk("score8_over", game_over, 0);
        end
        chk("win_scoreL", scoreL, 9);
        chk("win_over", game_over, 1);
        chk("win_led", led, 8'hFF);
        chk("win_divCR", div_CR, 0);
        serve();
        repeat (20) step(1, 1, 1, 1, 0);
        chk("over_hold_led", led, 8'hFF);
        chk("over_hold_scoreL", scoreL, 9);
        chk("over_hold_over", game_over, 1);

        step(0, 0, 0, 0, 0);
        repeat (4000) begin
            step($urandom_range(0, 299) != 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pingpong_ctrl.md
PINGPONG_CTRL -- requirements
Module: pingpong_ctrl

Interface
REQ-001 SHALL have parameter SPEED_INIT, default 4'd8, the divider load value at game start; tick period = 16 - load value cycles.
REQ-002 SHALL have parameter WIN_SCORE, default 4'd9, the score that ends the game.
REQ-003 SHALL have port CP  input  1  rising-edge clock; the block has exactly one clock.
REQ-004 SHALL have port CR  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port tick_CO  input  1  carry-out of the external 4-bit speed-divider counter; 1 = one ball step is due.
REQ-006 SHALL have ports BtnL, BtnR  input  1 each  debounced player hit buttons, level-sensitive, active-high.
REQ-007 SHALL have port Serve  input  1  serve button, level, active-high.
REQ-008 SHALL have ports div_CR, div_Ld  output  1 each  active-low clear and load to the divider.
REQ-009 SHALL have port div_D  output  4  divider load value.
REQ-010 SHALL have ports div_CTP, div_CTT  output  1 each  divider count enables.
REQ-011 SHALL have port led  output  8  ball position, one-hot; bit 0 = left end.
REQ-012 SHALL have ports scoreL, scoreR  output  4 each  binary scores.
REQ-013 SHALL have port game_over  output  1  high in OVER state.

Function
REQ-014 SHALL implement FSM states IDLE, MOVE_R, MOVE_L, POINT, OVER.
REQ-015 SHALL register BtnL, BtnR and Serve once; an event SHALL be the rising edge (cur & ~prev), detected one cycle after the input changes.
REQ-016 IDLE/POINT: Serve edge SHALL start a rally; server L -> pos 0, MOVE_R; server R -> pos 7, MOVE_L. Initial server is L.
REQ-017 In MOVE_R/MOVE_L: div_CR=1, div_CTP=div_CTT=1, div_Ld = ~tick_CO (combinational), so the divider reloads div_D instead of wrapping.
REQ-018 In IDLE/POINT/OVER: div_CR=0, div_CTP=div_CTT=0, div_Ld=1.
REQ-019 MOVE_R, tick_CO=1, pos<7: pos SHALL increment at the same edge; MOVE_L, pos>0: pos SHALL decrement.
REQ-020 MOVE_R, pos==7, BtnR edge: SHALL enter MOVE_L; pos unchanged. MOVE_L, pos==0, BtnL edge: SHALL enter MOVE_R.
REQ-021 MOVE_R, pos==7, tick_CO=1, no BtnR edge: miss; scoreL+1, server <= R, enter POINT. Mirror for MOVE_L at pos 0: scoreR+1, server <= L.
REQ-022 A hit edge and tick_CO in the same cycle at the end position SHALL count as a hit.
REQ-023 Button edges away from the end position, and the non-facing player's button, SHALL be ignored; Serve SHALL be ignored in MOVE_R, MOVE_L and OVER.
REQ-024 When an updated score equals WIN_SCORE, the FSM SHALL enter OVER instead of POINT; scores never exceed WIN_SCORE.
REQ-025 led SHALL be 1<<pos in MOVE_R/MOVE_L, 8'h00 in IDLE/POINT, and 8'hFF in OVER; game_over=1 only in OVER.
REQ-026 OVER SHALL be left only by reset.

Reset
REQ-027 With CR=0 at a CP rising edge: state=IDLE, pos=0, server=L, scoreL=scoreR=0, div_D=SPEED_INIT, button history=0, led=0, game_over=0.
REQ-028 Reset mid-rally SHALL abort the rally at that edge; no score update.

Configuration
REQ-029 Macro PINGPONG_SPEEDUP_EN defined: each successful hit SHALL increment div_D by 1, saturating at 4'd14; div_D SHALL return to SPEED_INIT at every serve.
REQ-030 Macro undefined: div_D SHALL stay at SPEED_INIT at all times.

Verification
REQ-031 Reset, Serve pulse, tick_CO every 8 cycles, no buttons -> led walks 01,02,..,80, then POINT with scoreL=1, led=00, div_CR=0.
REQ-032 Ball at pos 7 in MOVE_R, BtnR pulse in the same cycle as tick_CO -> MOVE_L, then led 80 -> 40 on the next tick; scores unchanged.
REQ-033 BtnR pulse at pos 3 -> ignored; ball reaches 7 and misses without a hit -> scoreL+1, next serve starts from pos 7 in MOVE_L.
REQ-034 scoreL=8, left wins a point -> scoreL=9, game_over=1, led=FF; Serve pulse -> no change until CR=0.
REQ-035 With PINGPONG_SPEEDUP_EN: 3 hits -> div_D=11; next serve -> div_D=8. Without the macro: div_D=8 throughout.
REQ-036 CR=0 for one cycle mid-rally at pos 4 -> next cycle state IDLE, led=00, scores 0, div_CR=0.
